// File: rtl/pattern_sequencer.sv
// Playback controller for the pattern buffer bank: steps bufp/fieldp through the
// pattern_sequence entries and hands the bank to the serial loader between playbacks.
module pattern_sequencer #(
    parameter int NFIELDS = 27,
    parameter int NSEQ    = 3,
    parameter int BUFW    = 3,
    parameter int FIELDW  = 5,
    parameter int SEQW    = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop,
    input  logic              stop,
    input  logic              field_tick,
    input  logic [NSEQ*8-1:0] seq_flat,
    input  logic              load_req,
    output logic              ssel,
    output logic [BUFW-1:0]   bufp,
    output logic [FIELDW-1:0] fieldp,
    output logic [SEQW-1:0]   seq_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [FIELDW-1:0] LAST_FIELD = FIELDW'(NFIELDS - 1);
    localparam logic [SEQW-1:0]   LAST_SEQ   = SEQW'(NSEQ - 1);

    state_t            state_q, state_d;
    logic [BUFW-1:0]   bufp_q, bufp_d;
    logic [FIELDW-1:0] fieldp_q, fieldp_d;
    logic [SEQW-1:0]   seq_idx_q, seq_idx_d;
    logic [4:0]        rep_q, rep_d;
    logic              stop_pend_q, stop_pend_d;

    // Table padded to a power of two so any seq_idx value indexes a defined entry.
    logic [7:0]      entry [2**SEQW];
    logic [SEQW-1:0] next_idx;

    always_comb begin
        for (int i = 0; i < 2**SEQW; i++) begin
            entry[i] = (i < NSEQ) ? seq_flat[8*i +: 8] : 8'h00;
        end
    end

    assign next_idx = seq_idx_q + 1'b1;

    // State register and datapath registers.
    always_ff @(posedge sclk) begin
        // NOTE: every register here uses <= so all of them see the pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bufp_q      <= '0;
            fieldp_q    <= '0;
            seq_idx_q   <= '0;
            rep_q       <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bufp_q      <= bufp_d;
            fieldp_q    <= fieldp_d;
            seq_idx_q   <= seq_idx_d;
            rep_q       <= rep_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        state_d     = state_q;
        bufp_d      = bufp_q;
        fieldp_d    = fieldp_q;
        seq_idx_d   = seq_idx_q;
        rep_d       = rep_q;
        stop_pend_d = stop_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                end else if (start) begin
                    if (entry[0][7:3] == 5'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        bufp_d    = BUFW'(entry[0][2:0]);
                        fieldp_d  = '0;
                        rep_d     = entry[0][7:3];
                        seq_idx_d = '0;
                    end
                end
            end

            S_RUN: begin
                if (stop) stop_pend_d = 1'b1;
                if (field_tick) begin
                    if (fieldp_q != LAST_FIELD) begin
                        fieldp_d = fieldp_q + 1'b1;
                    end else begin
                        fieldp_d = '0;
                        // A stop arriving on the last tick of a field still ends playback here.
                        if (stop_pend_q || stop) begin
                            state_d = S_DONE;
                        end else if (rep_q > 5'd1) begin
                            rep_d = rep_q - 5'd1;
                        end else if (seq_idx_q < LAST_SEQ && entry[next_idx][7:3] != 5'd0) begin
                            bufp_d    = BUFW'(entry[next_idx][2:0]);
                            rep_d     = entry[next_idx][7:3];
                            seq_idx_d = next_idx;
                        end else if (loop && !load_req && entry[0][7:3] != 5'd0) begin
                            bufp_d    = BUFW'(entry[0][2:0]);
                            rep_d     = entry[0][7:3];
                            seq_idx_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                if (state_d != S_RUN) stop_pend_d = 1'b0;
            end

            S_DONE: begin
                fieldp_d = '0;
                state_d  = load_req ? S_LOAD : S_IDLE;
            end

            S_LOAD: begin
                if (!load_req) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        ssel    = (state_q == S_LOAD);
        bufp    = bufp_q;
        fieldp  = fieldp_q;
        seq_idx = seq_idx_q;
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: playback, repeats, looping, stop, loader
// arbitration and synchronous reset, with expected values computed here.
module tb_pattern_sequencer;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        loop;
    logic        stop;
    logic        field_tick;
    logic [23:0] seq_flat;
    logic        load_req;
    logic        ssel;
    logic [2:0]  bufp;
    logic [4:0]  fieldp;
    logic [1:0]  seq_idx;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt;

    pattern_sequencer dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .start      (start),
        .loop       (loop),
        .stop       (stop),
        .field_tick (field_tick),
        .seq_flat   (seq_flat),
        .load_req   (load_req),
        .ssel       (ssel),
        .bufp       (bufp),
        .fieldp     (fieldp),
        .seq_idx    (seq_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 ns after it, away from the edge.
    task automatic cyc();
        @(posedge sclk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ssel"},    32'(ssel),    32'd0);
        check({tag, ".bufp"},    32'(bufp),    32'd0);
        check({tag, ".fieldp"},  32'(fieldp),  32'd0);
        check({tag, ".seq_idx"}, 32'(seq_idx), 32'd0);
        check({tag, ".busy"},    32'(busy),    32'd0);
        check({tag, ".done"},    32'(done),    32'd0);
    endtask

    initial begin
        int seg;
        rst_n = 1'b0; start = 1'b0; loop = 1'b0; stop = 1'b0;
        field_tick = 1'b0; load_req = 1'b0; seq_flat = '0;
        cyc(); cyc();
        check_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Test 1: single entry R=1 buf2, entry 1 empty.
        seq_flat = {8'h00, 8'h00, 8'h0A};
        start = 1'b1; cyc(); start = 1'b0;
        check("t1.busy_start", 32'(busy), 32'd1);
        check("t1.bufp_start", 32'(bufp), 32'd2);
        check("t1.fieldp_start", 32'(fieldp), 32'd0);
        field_tick = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            cyc();
            if (k < 27) begin
                check("t1.fieldp", 32'(fieldp), 32'(k));
                check("t1.bufp", 32'(bufp), 32'd2);
                check("t1.done_early", 32'(done), 32'd0);
            end else begin
                check("t1.done", 32'(done), 32'd1);
                check("t1.busy_fall", 32'(busy), 32'd0);
                check("t1.fieldp_wrap", 32'(fieldp), 32'd0);
            end
        end
        field_tick = 1'b0;
        cyc();
        check("t1.done_one_cycle", 32'(done), 32'd0);
        check("t1.busy_idle", 32'(busy), 32'd0);

        // Test 2: R2 buf1, R1 buf5, R1 buf7.
        seq_flat = {8'h0F, 8'h0D, 8'h11};
        start = 1'b1; cyc(); start = 1'b0;
        check("t2.bufp_start", 32'(bufp), 32'd1);
        done_cnt = 0;
        field_tick = 1'b1;
        for (int k = 1; k <= 108; k++) begin
            cyc();
            if (done) done_cnt++;
            if (k < 108) begin
                seg = k / 27;
                check("t2.fieldp", 32'(fieldp), 32'(k % 27));
                check("t2.bufp", 32'(bufp), (seg < 2) ? 32'd1 : (seg == 2) ? 32'd5 : 32'd7);
                check("t2.seq_idx", 32'(seq_idx), (seg < 2) ? 32'd0 : 32'(seg - 1));
                check("t2.busy", 32'(busy), 32'd1);
            end
        end
        field_tick = 1'b0;
        check("t2.done_end", 32'(done), 32'd1);
        check("t2.bufp_hold", 32'(bufp), 32'd7);
        check("t2.seq_hold", 32'(seq_idx), 32'd2);
        cyc();
        if (done) done_cnt++;
        check("t2.done_pulses", 32'(done_cnt), 32'd1);

        // Test 3: looping single entry, then stop mid-field.
        seq_flat = {8'h00, 8'h00, 8'h0A};
        loop = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        done_cnt = 0;
        field_tick = 1'b1;
        for (int k = 1; k <= 91; k++) begin
            cyc();
            if (done) done_cnt++;
            check("t3.fieldp", 32'(fieldp), 32'(k % 27));
            check("t3.busy", 32'(busy), 32'd1);
        end
        check("t3.no_done", 32'(done_cnt), 32'd0);
        field_tick = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("t3.stop_fieldp", 32'(fieldp), 32'd10);
        check("t3.stop_busy", 32'(busy), 32'd1);
        field_tick = 1'b1;
        for (int k = 11; k <= 26; k++) begin
            cyc();
            check("t3.drain_busy", 32'(busy), 32'd1);
        end
        check("t3.fieldp_last", 32'(fieldp), 32'd26);
        cyc();
        field_tick = 1'b0;
        check("t3.done", 32'(done), 32'd1);
        check("t3.busy_fall", 32'(busy), 32'd0);
        loop = 1'b0;
        cyc();

        // Test 5: load_req beats start; empty sequence.
        start = 1'b1; load_req = 1'b1; cyc(); start = 1'b0;
        check("t5.ssel", 32'(ssel), 32'd1);
        check("t5.busy", 32'(busy), 32'd0);
        load_req = 1'b0; cyc();
        check("t5.ssel_drop", 32'(ssel), 32'd0);
        seq_flat = 24'h000000;
        start = 1'b1; cyc(); start = 1'b0;
        check("t5.empty_done", 32'(done), 32'd1);
        check("t5.empty_busy", 32'(busy), 32'd0);
        cyc();
        check("t5.empty_done_off", 32'(done), 32'd0);
        check("t5.empty_busy_idle", 32'(busy), 32'd0);

        // Test 4: load request during playback is held until done.
        seq_flat = {8'h00, 8'h00, 8'h0A};
        start = 1'b1; cyc(); start = 1'b0;
        field_tick = 1'b1;
        for (int k = 1; k <= 5; k++) cyc();
        field_tick = 1'b0; load_req = 1'b1;
        cyc();
        check("t4.fieldp5", 32'(fieldp), 32'd5);
        check("t4.ssel_run", 32'(ssel), 32'd0);
        field_tick = 1'b1;
        for (int k = 6; k <= 26; k++) cyc();
        check("t4.ssel_run_late", 32'(ssel), 32'd0);
        check("t4.busy_late", 32'(busy), 32'd1);
        cyc();
        field_tick = 1'b0;
        check("t4.done", 32'(done), 32'd1);
        check("t4.ssel_at_done", 32'(ssel), 32'd0);
        cyc();
        check("t4.ssel_grant", 32'(ssel), 32'd1);
        check("t4.busy_load", 32'(busy), 32'd0);
        check("t4.bufp_hold", 32'(bufp), 32'd2);
        cyc();
        check("t4.ssel_hold", 32'(ssel), 32'd1);
        load_req = 1'b0; cyc();
        check("t4.ssel_release", 32'(ssel), 32'd0);
        start = 1'b1; cyc(); start = 1'b0;
        check("t4.idle_restart", 32'(busy), 32'd1);

        // Test 6: reset mid-RUN and mid-LOAD.
        field_tick = 1'b1;
        for (int k = 1; k <= 13; k++) cyc();
        field_tick = 1'b0;
        check("t6.fieldp13", 32'(fieldp), 32'd13);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check_zero("t6.run_reset");
        load_req = 1'b1; cyc();
        check("t6.load_entered", 32'(ssel), 32'd1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        load_req = 1'b0;
        check_zero("t6.load_reset");
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
